// File: rtl/coin_return_ctrl.sv
// coin_return_ctrl: idle-timeout / user-trigger change return controller.
// Dispenses the held credit one coin per valid/ready handshake, always picking
// the largest denomination that still fits, and reports the leftover that no
// coin can cover.
// Optional feature: define CHANGE_RETURN_GRACE_EN to insert a cancellable
// grace period between the user return trigger and dispensing.
module coin_return_ctrl #(
  parameter int unsigned NUM_COINS    = 3,
  parameter int unsigned TOTAL_BITS   = 31,
  parameter int unsigned WAIT_CYCLES  = 10,
  parameter int unsigned GRACE_CYCLES = 3,
  parameter int unsigned kNumItems    = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_COINS-1:0]            i_input_coin,
  input  logic [kNumItems-1:0]            i_output_item,
  input  logic                            i_trigger_return,
  input  logic [TOTAL_BITS-1:0]           i_current_total,
  input  logic [NUM_COINS*TOTAL_BITS-1:0] i_coin_value,
  output logic [NUM_COINS-1:0]            o_return_coin,
  output logic                            o_return_valid,
  input  logic                            i_return_ready,
  output logic [TOTAL_BITS-1:0]           o_deduct_value,
  output logic                            o_busy,
  output logic                            o_done,
  output logic [TOTAL_BITS-1:0]           o_residual,
  output logic [15:0]                     o_wait_time
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 65535 || GRACE_CYCLES > 65535) begin : g_bad_cfg
    $error("coin_return_ctrl: WAIT_CYCLES or GRACE_CYCLES out of range");
  end

  localparam logic [15:0] WAIT_LOAD = 16'(WAIT_CYCLES);

`ifdef CHANGE_RETURN_GRACE_EN
  localparam logic [15:0] GRACE_LOAD = 16'(GRACE_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_GRACE,
    S_DISPENSE,
    S_DONE
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_DISPENSE,
    S_DONE
  } state_t;
`endif

  state_t                state_q, state_d;
  logic [15:0]           timer_q, timer_d;
  logic [TOTAL_BITS-1:0] remaining_q, remaining_d;
  // High for the single reselection cycle that follows every accepted coin.
  logic                  gap_q, gap_d;
`ifdef CHANGE_RETURN_GRACE_EN
  logic [15:0]           grace_q, grace_d;
`endif

  logic                  activity;
  logic                  sel_fit;
  logic [NUM_COINS-1:0]  sel_coin;
  logic [TOTAL_BITS-1:0] sel_val;

  assign activity = (i_input_coin != '0) || (i_output_item != '0);

  // Greedy pick: the highest-index denomination not exceeding the remainder.
  always_comb begin
    sel_fit  = 1'b0;
    sel_coin = '0;
    sel_val  = '0;
    for (int unsigned k = 0; k < NUM_COINS; k++) begin
      if (i_coin_value[k*TOTAL_BITS +: TOTAL_BITS] <= remaining_q) begin
        sel_fit     = 1'b1;
        sel_coin    = '0;
        sel_coin[k] = 1'b1;
        sel_val     = i_coin_value[k*TOTAL_BITS +: TOTAL_BITS];
      end
    end
  end

  // Next-state, timer/remainder updates and registered-state-derived outputs.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    remaining_d = remaining_q;
    gap_d       = 1'b0;
`ifdef CHANGE_RETURN_GRACE_EN
    grace_d     = grace_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        timer_d = WAIT_LOAD;
        if (i_current_total != '0) begin
          state_d = S_COUNT;
        end
      end

      S_COUNT: begin
        if (i_current_total == '0) begin
          state_d = S_IDLE;
          timer_d = WAIT_LOAD;
        end else if (activity) begin
          timer_d = WAIT_LOAD;
        end else if (timer_q == '0) begin
          state_d     = S_DISPENSE;
          remaining_d = i_current_total;
        end else if (i_trigger_return) begin
`ifdef CHANGE_RETURN_GRACE_EN
          state_d = S_GRACE;
          grace_d = GRACE_LOAD;
`else
          state_d     = S_DISPENSE;
          remaining_d = i_current_total;
`endif
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end

`ifdef CHANGE_RETURN_GRACE_EN
      // The counter is treated as reaching 0 on the edge that leaves GRACE,
      // so the trigger costs exactly GRACE_CYCLES extra edges.
      S_GRACE: begin
        if (i_current_total == '0) begin
          state_d = S_IDLE;
          timer_d = WAIT_LOAD;
        end else if (activity) begin
          state_d = S_COUNT;
          timer_d = WAIT_LOAD;
        end else if (grace_q <= 16'd1) begin
          state_d     = S_DISPENSE;
          grace_d     = '0;
          remaining_d = i_current_total;
        end else begin
          grace_d = grace_q - 16'd1;
        end
      end
`endif

      S_DISPENSE: begin
        if (!sel_fit) begin
          state_d = S_DONE;
        end else if (!gap_q && i_return_ready) begin
          remaining_d = remaining_q - sel_val;
          gap_d       = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        timer_d = WAIT_LOAD;
      end

      default: begin
        state_d = S_IDLE;
        timer_d = WAIT_LOAD;
      end
    endcase

    o_return_valid = (state_q == S_DISPENSE) && !gap_q && sel_fit;
    o_return_coin  = o_return_valid ? sel_coin : '0;
    o_deduct_value = o_return_valid ? sel_val : '0;
    o_busy         = (state_q == S_DISPENSE) || (state_q == S_DONE);
    o_done         = (state_q == S_DONE);
    o_residual     = (state_q == S_DONE) ? remaining_q : '0;
    o_wait_time    = timer_q;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      timer_q     <= WAIT_LOAD;
      remaining_q <= '0;
      gap_q       <= 1'b0;
`ifdef CHANGE_RETURN_GRACE_EN
      grace_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      remaining_q <= remaining_d;
      gap_q       <= gap_d;
`ifdef CHANGE_RETURN_GRACE_EN
      grace_q     <= grace_d;
`endif
    end
  end

endmodule

// File: tb/tb_coin_return_ctrl.sv
// tb_coin_return_ctrl: table vectors, hand-written corner sequences and a
// randomized phase checked against a greedy change-making model.
// Define CHANGE_RETURN_GRACE_EN for both files to exercise the grace variant.
module tb_coin_return_ctrl;

  localparam int unsigned NC    = 3;
  localparam int unsigned TBITS = 31;
  localparam int unsigned WAIT  = 10;
  localparam int unsigned GRACE = 3;
  localparam int unsigned NI    = 4;
`ifdef CHANGE_RETURN_GRACE_EN
  localparam int unsigned TRIG_TICKS = GRACE + 1;
`else
  localparam int unsigned TRIG_TICKS = 1;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NC-1:0]         i_input_coin;
  logic [NI-1:0]         i_output_item;
  logic                  i_trigger_return;
  logic [TBITS-1:0]      i_current_total;
  logic [NC*TBITS-1:0]   i_coin_value;
  logic [NC-1:0]         o_return_coin;
  logic                  o_return_valid;
  logic                  i_return_ready;
  logic [TBITS-1:0]      o_deduct_value;
  logic                  o_busy;
  logic                  o_done;
  logic [TBITS-1:0]      o_residual;
  logic [15:0]           o_wait_time;

  coin_return_ctrl #(
    .NUM_COINS   (NC),
    .TOTAL_BITS  (TBITS),
    .WAIT_CYCLES (WAIT),
    .GRACE_CYCLES(GRACE),
    .kNumItems   (NI)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .i_input_coin    (i_input_coin),
    .i_output_item   (i_output_item),
    .i_trigger_return(i_trigger_return),
    .i_current_total (i_current_total),
    .i_coin_value    (i_coin_value),
    .o_return_coin   (o_return_coin),
    .o_return_valid  (o_return_valid),
    .i_return_ready  (i_return_ready),
    .o_deduct_value  (o_deduct_value),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_residual      (o_residual),
    .o_wait_time     (o_wait_time)
  );

  always #5 clk = ~clk;

  int unsigned val_tab [NC] = '{100, 500, 1000};
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  int unsigned got_q [$];
  int unsigned got_res;
  bit          got_done;
  int unsigned exp_q [$];
  int unsigned exp_res;

  typedef struct {
    int unsigned   total;
    int unsigned   ready_low;
    logic [NC-1:0] exp_first;
    int unsigned   exp_n;
    int unsigned   exp_res;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned coin_val(input logic [NC-1:0] c);
    int unsigned v = 0;
    for (int k = 0; k < NC; k++) if (c[k]) v = val_tab[k];
    return v;
  endfunction

  function automatic int unsigned idx_of(input logic [NC-1:0] c);
    int unsigned idx = 0;
    for (int k = 0; k < NC; k++) if (c[k]) idx = k;
    return idx;
  endfunction

  // Reference: greedy change making, largest coin first, by plain arithmetic.
  function automatic void greedy(input int unsigned total);
    int unsigned rem = total;
    exp_q.delete();
    for (int k = NC - 1; k >= 0; k--) begin
      while (rem >= val_tab[k]) begin
        exp_q.push_back(k);
        rem -= val_tab[k];
      end
    end
    exp_res = rem;
  endfunction

  task automatic go_idle();
    i_current_total  = '0;
    i_input_coin     = '0;
    i_output_item    = '0;
    i_trigger_return = 1'b0;
    i_return_ready   = 1'b0;
    tick();
    tick();
  endtask

  task automatic start_count(input int unsigned total);
    i_current_total = TBITS'(total);
    tick();
    check("count_entry_timer", o_wait_time, WAIT);
  endtask

  task automatic trigger();
    i_trigger_return = 1'b1;
    tick();
    i_trigger_return = 1'b0;
    for (int unsigned t = 1; t < TRIG_TICKS; t++) tick();
  endtask

  // Runs the dispense handshake from the current cycle until o_done.
  task automatic collect(input int unsigned ready_low, input bit rnd_ready);
    int unsigned   cyc = 0;
    int unsigned   last_acc = 0;
    bit            any_acc = 0;
    bit            prev_stall = 0;
    bit            prev_acc = 0;
    bit            r;
    logic [NC-1:0]    prev_coin = '0;
    logic [TBITS-1:0] prev_ded = '0;
    got_q.delete();
    got_done = 0;
    got_res  = 0;
    while (!got_done && cyc < 300) begin
      if (prev_stall) begin
        check("hold_valid", o_return_valid, 1);
        check("hold_coin", o_return_coin, prev_coin);
        check("hold_deduct", o_deduct_value, prev_ded);
      end
      if (prev_acc) check("reselect_gap", o_return_valid, 0);
      check("busy", o_busy, 1);
      if (o_done) begin
        got_done = 1;
        got_res  = o_residual;
        if (any_acc) check("done_latency", cyc - last_acc, 2);
      end else begin
        if (o_return_valid) begin
          check("onehot", $onehot(o_return_coin), 1);
          check("deduct_matches_coin", o_deduct_value, coin_val(o_return_coin));
        end
        r = (cyc >= ready_low) && (!rnd_ready || ($urandom_range(0, 1) == 1));
        i_return_ready = r;
        prev_stall = o_return_valid && !r;
        prev_acc   = o_return_valid && r;
        if (prev_acc) begin
          got_q.push_back(idx_of(o_return_coin));
          last_acc = cyc;
          any_acc  = 1;
        end
        prev_coin = o_return_coin;
        prev_ded  = o_deduct_value;
        tick();
        cyc++;
      end
    end
    i_return_ready = 1'b0;
    check("done_seen", got_done, 1);
  endtask

  task automatic compare_seq(input string tag);
    check({tag, "_ncoins"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, "_coin"}, got_q[i], exp_q[i]);
    check({tag, "_residual"}, got_res, exp_res);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned sum;
    int unsigned n;
    int unsigned total;
    int unsigned quiet;
    int unsigned k;
    int unsigned ticks;
    bit          act;

    vecs[0] = '{1600, 0, 3'b100, 3, 0};
    vecs[1] = '{1100, 5, 3'b100, 2, 0};
    vecs[2] = '{650,  0, 3'b010, 2, 50};
    vecs[3] = '{99,   0, 3'b000, 0, 99};
    vecs[4] = '{2750, 2, 3'b100, 5, 50};
    vecs[5] = '{100,  1, 3'b001, 1, 0};

    i_coin_value = {TBITS'(1000), TBITS'(500), TBITS'(100)};
    reset = 1'b1;
    go_idle();

    // Reset state.
    check("rst_coin", o_return_coin, 0);
    check("rst_valid", o_return_valid, 0);
    check("rst_deduct", o_deduct_value, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_residual", o_residual, 0);
    check("rst_timer", o_wait_time, WAIT);
    reset = 1'b0;
    tick();

    // Table vectors, trigger-started.
    for (int v = 0; v < 6; v++) begin
      go_idle();
      start_count(vecs[v].total);
      trigger();
      check("vec_busy_entry", o_busy, 1);
      check("vec_first_coin", o_return_coin, vecs[v].exp_first);
      check("vec_first_deduct", o_deduct_value, coin_val(vecs[v].exp_first));
      collect(vecs[v].ready_low, 0);
      check("vec_ncoins", got_q.size(), vecs[v].exp_n);
      check("vec_residual", got_res, vecs[v].exp_res);
      sum = got_res;
      foreach (got_q[i]) sum += val_tab[got_q[i]];
      check("vec_conservation", sum, vecs[v].total);
      for (int i = 1; i < got_q.size(); i++) check("vec_order", got_q[i] <= got_q[i-1], 1);
      i_current_total = '0;
      tick();
    end

    // Timeout: 1600 from a quiet COUNT entry, exact countdown and order.
    go_idle();
    start_count(1600);
    for (int unsigned t = 0; t <= WAIT; t++) begin
      check("to_countdown", o_wait_time, WAIT - t);
      check("to_not_busy", o_busy, 0);
      tick();
    end
    check("to_valid_first", o_return_valid, 1);
    check("to_coin_first", o_return_coin, 3'b100);
    collect(0, 0);
    greedy(1600);
    compare_seq("timeout");
    i_current_total = '0;
    tick();

    // Activity reload at timer=2, then 11 quiet edges to dispense.
    go_idle();
    start_count(500);
    n = 0;
    while (o_wait_time != 16'd2 && n < 20) begin
      tick();
      n++;
    end
    check("reload_reach_timer2", o_wait_time, 2);
    i_input_coin = 3'b001;
    tick();
    i_input_coin = '0;
    check("reload_timer", o_wait_time, WAIT);
    for (int unsigned t = 0; t <= WAIT; t++) begin
      check("reload_no_valid", o_return_valid, 0);
      tick();
    end
    check("reload_valid", o_return_valid, 1);
    check("reload_coin", o_return_coin, 3'b010);
    collect(0, 0);
    greedy(500);
    compare_seq("reload");
    i_current_total = '0;
    tick();

    // Reset after the first accepted coin aborts without o_done.
    go_idle();
    start_count(1600);
    trigger();
    check("rmid_valid", o_return_valid, 1);
    i_return_ready = 1'b1;
    tick();
    i_return_ready = 1'b0;
    check("rmid_gap", o_return_valid, 0);
    reset = 1'b1;
    i_current_total = '0;
    tick();
    reset = 1'b0;
    check("rmid_coin", o_return_coin, 0);
    check("rmid_valid_off", o_return_valid, 0);
    check("rmid_deduct", o_deduct_value, 0);
    check("rmid_busy", o_busy, 0);
    check("rmid_done", o_done, 0);
    check("rmid_residual", o_residual, 0);
    check("rmid_timer", o_wait_time, WAIT);
    for (int t = 0; t < 4; t++) begin
      tick();
      check("rmid_no_done", o_done, 0);
      check("rmid_idle", o_busy, 0);
    end

`ifdef CHANGE_RETURN_GRACE_EN
    // Grace: a coin strobe two cycles after the trigger cancels the request.
    go_idle();
    start_count(500);
    i_trigger_return = 1'b1;
    tick();
    i_trigger_return = 1'b0;
    check("grace_not_busy", o_busy, 0);
    tick();
    i_input_coin = 3'b001;
    tick();
    i_input_coin = '0;
    check("grace_cancel_timer", o_wait_time, WAIT);
    check("grace_cancel_busy", o_busy, 0);
    tick();
    check("grace_back_in_count", o_wait_time, WAIT - 1);
    check("grace_no_valid", o_return_valid, 0);
`endif

    // Randomized: activity mix, trigger or timeout, random backpressure.
    for (int it = 0; it < 40; it++) begin
      go_idle();
      total = $urandom_range(1, 3000);
      start_count(total);
      quiet = 0;
      k = $urandom_range(1, 8);
      for (int unsigned j = 0; j < k; j++) begin
        check("rnd_timer", o_wait_time, WAIT - quiet);
        act = ($urandom_range(0, 1) == 1);
        if (act) begin
          if ($urandom_range(0, 1) == 1) i_input_coin = NC'($urandom_range(1, (1 << NC) - 1));
          else                           i_output_item = NI'($urandom_range(1, (1 << NI) - 1));
          i_trigger_return = ($urandom_range(0, 1) == 1);
        end
        tick();
        i_input_coin     = '0;
        i_output_item    = '0;
        i_trigger_return = 1'b0;
        quiet = act ? 0 : quiet + 1;
        check("rnd_no_dispense", o_busy, 0);
      end
      check("rnd_timer_pre", o_wait_time, WAIT - quiet);
      if ($urandom_range(0, 1) == 1) begin
        trigger();
      end else begin
        ticks = WAIT - quiet + 1;
        for (int unsigned t = 0; t < ticks; t++) begin
          check("rnd_no_early", o_busy, 0);
          tick();
        end
      end
      check("rnd_busy_entry", o_busy, 1);
      check("rnd_valid_entry", o_return_valid, total >= val_tab[0]);
      collect(0, 1);
      greedy(total);
      compare_seq("rnd");
      i_current_total = '0;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
